// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock synchronous FIFO with first-word-fall-through output,
// exact (non power-of-two) capacity, occupancy count, programmable almost-full /
// almost-empty flags, synchronous flush and registered overflow/underflow pulses.
// Compile-time option: define FIFO_OVERWRITE_EN to make a write into a full FIFO
// (with no simultaneous read) replace the oldest word instead of being dropped.
module fifo_buffer #(
  parameter int WORD_SIZE          = 8,
  parameter int BUFFER_SIZE        = 256,
  parameter int ALMOST_FULL_LEVEL  = BUFFER_SIZE - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  localparam int COUNT_SIZE        = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_SIZE-1:0]  dataIn,
  input  logic                  we,
  input  logic                  oe,
  input  logic                  flush,
  output logic [WORD_SIZE-1:0]  dataOut,
  output logic                  isData,
  output logic                  bufferFull,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [COUNT_SIZE-1:0] count,
  output logic                  dataLost,
  output logic                  underflow
);

  localparam int PTR_SIZE = $clog2(BUFFER_SIZE);
  localparam logic [PTR_SIZE-1:0]   PTR_LAST = PTR_SIZE'(BUFFER_SIZE - 1);
  localparam logic [COUNT_SIZE-1:0] CNT_FULL = COUNT_SIZE'(BUFFER_SIZE);
  localparam logic [COUNT_SIZE-1:0] CNT_AF   = COUNT_SIZE'(ALMOST_FULL_LEVEL);
  localparam logic [COUNT_SIZE-1:0] CNT_AE   = COUNT_SIZE'(ALMOST_EMPTY_LEVEL);

  logic [WORD_SIZE-1:0]  r_mem [BUFFER_SIZE];
  logic [PTR_SIZE-1:0]   r_rd_ptr;
  logic [PTR_SIZE-1:0]   r_wr_ptr;
  logic [COUNT_SIZE-1:0] r_count;
  logic                  r_data_lost;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_accept;   // a real pop of the head word
  logic w_wr_accept;   // a real push that grows (or keeps, with a pop) occupancy
  logic w_drop;        // write attempted into a full FIFO with no pop
  logic w_overwrite;   // full-FIFO write replacing the oldest word
  logic w_mem_we;
  logic w_rd_adv;

  // Pointers wrap by explicit compare so any capacity works without rounding.
  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_FULL);
  assign w_rd_accept = oe && !w_empty && !flush;
  assign w_wr_accept = we && (!w_full || w_rd_accept) && !flush;
  assign w_drop      = we && w_full && !w_rd_accept && !flush;
`ifdef FIFO_OVERWRITE_EN
  assign w_overwrite = w_drop;
`else
  assign w_overwrite = 1'b0;
`endif
  assign w_mem_we    = w_wr_accept || w_overwrite;
  assign w_rd_adv    = w_rd_accept || w_overwrite;

  // Storage array: written on every stored word, never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  // Pointer, occupancy and event-pulse registers; flush wins over read/write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_data_lost <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_data_lost <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_mem_we) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wr_accept && !w_rd_accept) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_accept && !w_wr_accept) begin
        r_count <= r_count - 1'b1;
      end
      r_data_lost <= w_drop;
      r_underflow <= oe && w_empty;
    end
  end

  // All outputs come from registered state only.
  assign dataOut     = r_mem[r_rd_ptr];
  assign count       = r_count;
  assign isData      = !w_empty;
  assign bufferFull  = w_full;
  assign almostFull  = (r_count >= CNT_AF);
  assign almostEmpty = (r_count <= CNT_AE);
  assign dataLost    = r_data_lost;
  assign underflow   = r_underflow;

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised single-clock synchronous FIFO; successor to the peripheral byte FIFO, used by UART, SPI and debug-stream peripherals between the Wishbone register file and the serialisers. Generalises word width and depth: any depth at or above 2, with no power-of-two rounding and no reserved empty slot. Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow pulses. An optional overwrite-oldest mode is selected at compile time.

## Interface
- WORD_SIZE, 8, data width in bits (≥1)
- BUFFER_SIZE, 256, exact capacity in words (≥2, any integer)
- ALMOST_FULL_LEVEL, BUFFER_SIZE-1, almostFull threshold (1..BUFFER_SIZE)
- ALMOST_EMPTY_LEVEL, 1, almostEmpty threshold (0..BUFFER_SIZE-1)
- COUNT_SIZE (localparam) = $clog2(BUFFER_SIZE+1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- dataIn  in  WORD_SIZE  write data
- we  in  1  write request
- oe  in  1  read request; pops the head word
- flush  in  1  synchronous clear
- dataOut  out  WORD_SIZE  head word, first-word-fall-through
- isData  out  1  count != 0
- bufferFull  out  1  count == BUFFER_SIZE
- almostFull  out  1  count >= ALMOST_FULL_LEVEL
- almostEmpty  out  1  count <= ALMOST_EMPTY_LEVEL
- count  out  COUNT_SIZE  current occupancy
- dataLost  out  1  one-cycle pulse: a word was dropped
- underflow  out  1  one-cycle pulse: oe while empty

## Operation
- Storage: BUFFER_SIZE-entry array, read pointer, write pointer, count register.
- Pointers wrap from BUFFER_SIZE-1 to 0 by explicit compare. No modulo-2^n arithmetic.
- Reset (rst_n low, asynchronous):
  - pointers, count, dataLost and underflow clear to 0.
  - Outputs: isData=0, bufferFull=0, almostFull=0, almostEmpty=1, count=0.
  - Array contents are not reset. dataOut is undefined until the first write.
- Priority per posedge: flush > read/write.
- flush: pointers and count go to 0; dataLost and underflow go to 0. Any we/oe in the same cycle is ignored.
- Read: oe && count!=0 advances the read pointer.
- Read when empty: oe && count==0 → no state change; underflow=1 next cycle.
- Write: we && (count<BUFFER_SIZE || read accepted this cycle) stores dataIn at the write pointer and advances it.
- Full with simultaneous read: write is accepted; count stays BUFFER_SIZE.
- Full with no read: write is rejected; dataLost=1 next cycle. Overwrite behaviour is covered under Configuration.
- Empty with simultaneous read: the read is rejected and the write proceeds. No bypass of dataIn to dataOut within the same cycle.
- count: +1 on an accepted write only, -1 on an accepted read only, otherwise unchanged.
- dataLost and underflow are registered. Each is high for exactly one cycle per offending request. Back-to-back offences keep them high.

## Timing
- Write-to-output latency: a word written at edge N is visible on dataOut and isData after edge N (a zero-wait read at edge N+1 is legal).
- dataOut updates after each accepted read edge to show the next word.
- All flags derive combinationally from the registered count, so they change only after a clock edge.
- No combinational path from we/oe/dataIn to any output.

## Configuration
- FIFO_OVERWRITE_EN defined:
  - A write when full with no read stores dataIn at the write pointer and advances both pointers.
  - The oldest word is discarded; count stays BUFFER_SIZE; dataLost=1 next cycle.
  - The new word is retained.
- FIFO_OVERWRITE_EN undefined: the new word is discarded as described in Operation.

## Test plan
WORD_SIZE=8, BUFFER_SIZE=5, ALMOST_FULL_LEVEL=4, ALMOST_EMPTY_LEVEL=1.
- Reset mid-traffic: write 0x11,0x22, then pulse rst_n low between edges → outputs clear immediately (asynchronously): count=0, isData=0, almostEmpty=1.
- Fill and wrap: write 0x01..0x05 → count=5, bufferFull=1, almostFull=1 after the 4th write. Read 3, write 0x06..0x08, read 5 → dataOut sequence 0x01..0x08 in order.
- Overflow without FIFO_OVERWRITE_EN: full with 0x01..0x05, write 0xAA → dataLost high one cycle, count=5, reads return 0x01..0x05. With the macro: reads return 0x02..0x05,0xAA.
- Simultaneous read/write at full and at empty:
  - Full: we+oe → count stays 5, head advances.
  - Empty: we=0x33 with oe → count=1, dataOut=0x33, underflow pulses.
- Underflow on empty read: oe for 2 cycles while empty → underflow high 2 cycles, count stays 0.
- Flush priority: count=3, assert flush with we=1 and oe=1 → count=0, isData=0, the new word is not stored.
